// File: rtl/fir_sample_serializer_if.sv
// Sample-in / serial-out bundle for fir_sample_serializer.
// The filter side drives valid_in/y_in and the serializer drives the
// 3-wire link (sclk, sdata, sframe) plus its status flags.
interface fir_sample_serializer_if #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
);
  logic                              valid_in;
  logic signed [DATA_W-1:0]          y_in;
  logic                              sclk;
  logic                              sdata;
  logic                              sframe;
  logic                              busy;
  logic                              overflow;
  logic [$clog2(FIFO_DEPTH):0]       fifo_level;

  modport master (
    output valid_in, y_in,
    input  sclk, sdata, sframe, busy, overflow, fifo_level
  );

  modport slave (
    input  valid_in, y_in,
    output sclk, sdata, sframe, busy, overflow, fifo_level
  );
endinterface

// File: rtl/fir_sample_serializer.sv
// Buffers the FIR filter's result stream in a small FIFO and sends each
// sample MSB-first over a framed 3-wire serial link. Words are separated by
// one idle bit period; samples arriving into a full FIFO are dropped and
// flagged with a one-cycle overflow pulse. All link outputs are registered.
module fir_sample_serializer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fir_sample_serializer_if.slave   bus
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int DIVW = $clog2(CLK_DIV);
  localparam int BW   = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [LW-1:0]   LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]   LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV / 2);
  localparam logic [BW-1:0]   BIT_ONE  = BW'(1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     count_r;

  // Serializer state
  state_t            state_r;
  logic [DIVW-1:0]   div_r;
  logic [BW-1:0]     bit_cnt_r;
  logic [DATA_W-1:0] shreg_r;

  // Registered outputs
  logic              sclk_r;
  logic              sdata_r;
  logic              sframe_r;
  logic              busy_r;
  logic              overflow_r;

  // Handshake between FIFO and FSM
  logic              pop_s;
  logic              push_s;
  logic              full_s;
  logic [DATA_W-1:0] head_s;

  assign full_s = (count_r == LVL_FULL);
  assign head_s = mem_r[rd_ptr_r];

  // Pop decision: the FSM takes a word when idle or on the final gap cycle, if one is waiting
  always_comb begin
    pop_s = 1'b0;
    if (count_r != {LW{1'b0}}) begin
      if (state_r == IDLE) begin
        pop_s = 1'b1;
      end else if ((state_r == GAP) && (div_r == DIV_LAST)) begin
        pop_s = 1'b1;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // Push decision: accept when there is room, or when a pop frees a slot this cycle
  always_comb begin
    push_s = 1'b0;
    if (bus.valid_in && (!full_s || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // FIFO: circular buffer with wrapping pointers, occupancy counter and drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {LW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.y_in;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LVL_ONE;
        2'b01:   count_r <= count_r - LVL_ONE;
        default: count_r <= count_r;
      endcase
      overflow_r <= bus.valid_in && !push_s;
    end
  end

  // Serial framing FSM: loads words, divides clk into bit periods and drives the link outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      div_r     <= {DIVW{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      shreg_r   <= {DATA_W{1'b0}};
      sclk_r    <= 1'b0;
      sdata_r   <= 1'b0;
      sframe_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          div_r     <= {DIVW{1'b0}};
          bit_cnt_r <= {BW{1'b0}};
          sclk_r    <= 1'b0;
          if (pop_s) begin
            state_r  <= SHIFT;
            shreg_r  <= head_s;
            sframe_r <= 1'b1;
            sdata_r  <= head_s[DATA_W-1];
            busy_r   <= 1'b1;
          end else begin
            state_r  <= IDLE;
            sframe_r <= 1'b0;
            sdata_r  <= 1'b0;
            busy_r   <= push_s;
          end
        end

        SHIFT: begin
          busy_r <= 1'b1;
          if (div_r == DIV_LAST) begin
            // Bit period complete: advance to the next bit or close the frame
            div_r   <= {DIVW{1'b0}};
            shreg_r <= {shreg_r[DATA_W-2:0], 1'b0};
            sclk_r  <= 1'b0;
            if (bit_cnt_r == BIT_LAST) begin
              state_r   <= GAP;
              bit_cnt_r <= {BW{1'b0}};
              sframe_r  <= 1'b0;
              sdata_r   <= 1'b0;
            end else begin
              state_r   <= SHIFT;
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
              sframe_r  <= 1'b1;
              sdata_r   <= shreg_r[DATA_W-2];
            end
          end else begin
            // sclk rises in the second half of the bit so the receiver samples mid-bit
            state_r  <= SHIFT;
            div_r    <= div_r + DIV_ONE;
            sclk_r   <= ((div_r + DIV_ONE) >= DIV_HALF);
            sframe_r <= 1'b1;
            sdata_r  <= shreg_r[DATA_W-1];
          end
        end

        GAP: begin
          sclk_r <= 1'b0;
          if (div_r == DIV_LAST) begin
            div_r     <= {DIVW{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            if (pop_s) begin
              // Back-to-back word: skip IDLE entirely
              state_r  <= SHIFT;
              shreg_r  <= head_s;
              sframe_r <= 1'b1;
              sdata_r  <= head_s[DATA_W-1];
              busy_r   <= 1'b1;
            end else begin
              state_r  <= IDLE;
              sframe_r <= 1'b0;
              sdata_r  <= 1'b0;
              busy_r   <= push_s;
            end
          end else begin
            state_r  <= GAP;
            div_r    <= div_r + DIV_ONE;
            sframe_r <= 1'b0;
            sdata_r  <= 1'b0;
            busy_r   <= 1'b1;
          end
        end

        default: begin
          state_r   <= IDLE;
          div_r     <= {DIVW{1'b0}};
          bit_cnt_r <= {BW{1'b0}};
          shreg_r   <= {DATA_W{1'b0}};
          sclk_r    <= 1'b0;
          sdata_r   <= 1'b0;
          sframe_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sclk       = sclk_r;
  assign bus.sdata      = sdata_r;
  assign bus.sframe     = sframe_r;
  assign bus.busy       = busy_r;
  assign bus.overflow   = overflow_r;
  assign bus.fifo_level = count_r;

endmodule

// File: tb/tb_fir_sample_serializer.sv
// Directed bench for fir_sample_serializer: reset, single word, back-to-back
// words, overflow, push-at-full with pop, mid-word reset and a paced random stream.
module tb_fir_sample_serializer;

  logic clk;
  logic rst_n;

  fir_sample_serializer_if #(.DATA_W(16), .FIFO_DEPTH(4)) bus ();

  fir_sample_serializer #(.DATA_W(16), .FIFO_DEPTH(4), .CLK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Serial receiver model state
  logic [15:0] rx_q[$];
  int          rx_bits_q[$];
  logic [15:0] rx_sh;
  int          rx_nb;
  logic        prev_sclk;
  logic        prev_sframe;
  int          low_cnt;
  int          last_gap;
  int          frames_started;
  int          ovf_cnt;

  initial begin
    frames_started = 0;
    ovf_cnt        = 0;
    last_gap       = 0;
  end

  // Receiver: shifts sdata on sclk rising while sframe is high, stores each frame at sframe fall
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_sh       <= 16'h0000;
      rx_nb       <= 0;
      prev_sclk   <= 1'b0;
      prev_sframe <= 1'b0;
      low_cnt     <= 0;
    end else begin
      if (bus.sframe && !prev_sframe) begin
        frames_started <= frames_started + 1;
        last_gap       <= low_cnt;
        rx_sh          <= 16'h0000;
        rx_nb          <= 0;
      end else if (bus.sclk && !prev_sclk && bus.sframe) begin
        rx_sh <= {rx_sh[14:0], bus.sdata};
        rx_nb <= rx_nb + 1;
      end
      if (!bus.sframe && prev_sframe) begin
        rx_q.push_back(rx_sh);
        rx_bits_q.push_back(rx_nb);
      end
      if (bus.sframe) low_cnt <= 0;
      else            low_cnt <= low_cnt + 1;
      if (bus.overflow) ovf_cnt <= ovf_cnt + 1;
      prev_sclk   <= bus.sclk;
      prev_sframe <= bus.sframe;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles && bus.busy !== 1'b0; i++) tick();
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_sframe_low(input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles && bus.sframe !== 1'b0; i++) tick();
    chk(tag, 32'(bus.sframe), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_sclk"},   32'(bus.sclk),       32'd0);
    chk({tag, "_sdata"},  32'(bus.sdata),      32'd0);
    chk({tag, "_sframe"}, 32'(bus.sframe),     32'd0);
    chk({tag, "_busy"},   32'(bus.busy),       32'd0);
    chk({tag, "_ovf"},    32'(bus.overflow),   32'd0);
    chk({tag, "_level"},  32'(bus.fifo_level), 32'd0);
  endtask

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int          hi;
  int          base;
  int          fr0;
  int          mism;
  int          gap;
  int          ovf0;
  logic [15:0] v;
  logic [15:0] exp_q[$];
  logic [15:0] ovf_exp[6];

  // Directed stimulus and checks
  initial begin
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.y_in     = 16'sh0000;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_level", 32'(bus.fifo_level), 32'd0);

    // Single word 16'hA5C3
    bus.valid_in = 1'b1;
    bus.y_in     = 16'shA5C3;
    tick();
    bus.valid_in = 1'b0;
    chk("sw_level_written", 32'(bus.fifo_level), 32'd1);
    chk("sw_busy",          32'(bus.busy),       32'd1);
    chk("sw_sframe_pre",    32'(bus.sframe),     32'd0);
    tick();
    chk("sw_sframe_rise", 32'(bus.sframe),     32'd1);
    chk("sw_msb",         32'(bus.sdata),      32'd1);
    chk("sw_level_pop",   32'(bus.fifo_level), 32'd0);
    hi = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.sframe !== 1'b1) break;
      hi++;
    end
    chk("sw_frame_len", 32'(hi), 32'd64);
    repeat (3) tick();
    chk("sw_busy_in_gap", 32'(bus.busy), 32'd1);
    tick();
    chk("sw_busy_done", 32'(bus.busy), 32'd0);
    chk("sw_rx_count", 32'(rx_q.size()), 32'd1);
    chk("sw_word",     32'(rx_q[0]),      32'h0000A5C3);
    chk("sw_bits",     32'(rx_bits_q[0]), 32'd16);

    // Back-to-back 16'h8000 then 16'h7FFF, two cycles apart
    bus.valid_in = 1'b1;
    bus.y_in     = 16'sh8000;
    tick();
    bus.valid_in = 1'b0;
    tick();
    bus.valid_in = 1'b1;
    bus.y_in     = 16'sh7FFF;
    tick();
    bus.valid_in = 1'b0;
    wait_idle(400, "b2b_timeout");
    chk("b2b_rx_count", 32'(rx_q.size()), 32'd3);
    chk("b2b_word0",    32'(rx_q[1]),     32'h00008000);
    chk("b2b_word1",    32'(rx_q[2]),     32'h00007FFF);
    chk("b2b_gap",      32'(last_gap),    32'd4);

    // Overflow: six consecutive samples 1..6, only 6 is dropped
    for (int k = 1; k <= 6; k++) begin
      bus.valid_in = 1'b1;
      bus.y_in     = 16'(k);
      tick();
      chk("of_pulse", 32'(bus.overflow), (k == 6) ? 32'd1 : 32'd0);
    end
    bus.valid_in = 1'b0;
    chk("of_level_full", 32'(bus.fifo_level), 32'd4);
    tick();
    chk("of_pulse_end", 32'(bus.overflow), 32'd0);

    // Push at full on the final gap cycle: accepted through the simultaneous pop
    wait_sframe_low(200, "of_frame_end_timeout");
    repeat (3) tick();
    chk("pf_level_before", 32'(bus.fifo_level), 32'd4);
    chk("pf_in_gap",       32'(bus.sframe),     32'd0);
    bus.valid_in = 1'b1;
    bus.y_in     = 16'sh0007;
    tick();
    bus.valid_in = 1'b0;
    chk("pf_level_after", 32'(bus.fifo_level), 32'd4);
    chk("pf_no_ovf",      32'(bus.overflow),   32'd0);
    chk("pf_next_frame",  32'(bus.sframe),     32'd1);
    wait_idle(600, "of_timeout");
    chk("of_rx_count", 32'(rx_q.size()), 32'd9);
    ovf_exp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd7};
    for (int k = 0; k < 6; k++) begin
      chk("of_word", 32'(rx_q[3 + k]), 32'(ovf_exp[k]));
    end
    chk("of_ovf_count", 32'(ovf_cnt), 32'd1);

    // Reset mid-word with a word waiting in the FIFO
    bus.valid_in = 1'b1;
    bus.y_in     = 16'sh1234;
    tick();
    bus.y_in     = 16'sh5678;
    tick();
    bus.valid_in = 1'b0;
    repeat (20) tick();
    chk("mr_in_frame", 32'(bus.sframe),     32'd1);
    chk("mr_level",    32'(bus.fifo_level), 32'd1);
    base = rx_q.size();
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("mr_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fr0 = frames_started;
    repeat (200) tick();
    chk("mr_no_frames", 32'(frames_started), 32'(fr0));
    chk("mr_no_words",  32'(rx_q.size()),    32'(base));
    chk("mr_busy",      32'(bus.busy),       32'd0);
    chk("mr_level_after", 32'(bus.fifo_level), 32'd0);

    // Random stream paced no faster than one word period
    base = rx_q.size();
    ovf0 = ovf_cnt;
    for (int k = 0; k < 20; k++) begin
      gap = $urandom_range(120, 68);
      v   = 16'($urandom);
      bus.valid_in = 1'b1;
      bus.y_in     = v;
      exp_q.push_back(v);
      tick();
      bus.valid_in = 1'b0;
      repeat (gap - 1) tick();
    end
    wait_idle(300, "rnd_timeout");
    chk("rnd_rx_count", 32'(rx_q.size()), 32'(base + 20));
    mism = 0;
    for (int k = 0; k < 20; k++) begin
      if (rx_q.size() <= base + k || rx_q[base + k] !== exp_q[k]) mism++;
    end
    chk("rnd_mismatches", 32'(mism), 32'd0);
    chk("rnd_drops",      32'(ovf_cnt - ovf0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_sample_serializer.md
# fir_sample_serializer

Output-side companion to the 8-tap pipelined FIR filter. It receives the filter's signed 16-bit result stream (sample plus one-cycle valid strobe) and buffers it in a small FIFO. It then transmits each sample MSB-first over a 3-wire framed serial link (sclk, sdata, sframe) toward an off-chip DAC or logger. It decouples the filter's burst output rate from the slower serial bit rate and reports dropped samples.

## Interface
Parameters:
- DATA_W, 16, sample width in bits; matches the filter output width.
- FIFO_DEPTH, 4, FIFO entries; power of 2, ≥ 2.
- CLK_DIV, 4, clk cycles per serial bit; even, ≥ 2.

Ports:
- Clock clk; reset rst_n, asynchronous, active-low.
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  one-cycle strobe: y_in holds a new sample.
- y_in  in  DATA_W  signed sample, two's complement.
- sclk  out  1  serial bit clock; low when idle.
- sdata  out  1  serial data; MSB first; changes only while sclk is low.
- sframe  out  1  high for exactly DATA_W bit periods per word.
- busy  out  1  high when state is not IDLE or the FIFO is non-empty.
- overflow  out  1  one-cycle pulse when a sample is dropped.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **FIFO.** Circular buffer with write/read pointers that wrap at FIFO_DEPTH, plus an occupancy counter.
  - On valid_in, y_in is written if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the sample is discarded, FIFO contents are unchanged, and overflow pulses high for 1 cycle.
  - A simultaneous push and pop leaves fifo_level unchanged.
- **FSM states.**
  - IDLE:
    - sclk = 0, sframe = 0, sdata = 0.
    - If fifo_level ≠ 0: pop the head into the shift register, clear the bit counter and divider, go to SHIFT.
  - SHIFT:
    - sframe = 1; sdata = shift register MSB.
    - Divider counts 0..CLK_DIV-1. sclk = 0 for counts < CLK_DIV/2 and 1 for the remainder, so the receiver samples on sclk rising.
    - At divider = CLK_DIV-1: shift left by 1 and increment the bit counter.
    - After bit DATA_W-1 completes, go to GAP.
  - GAP:
    - One bit period (CLK_DIV cycles) with sframe = 0, sclk = 0, sdata = 0.
    - On the last cycle, if the FIFO is non-empty, pop directly into SHIFT (no IDLE cycle). Otherwise go to IDLE.
- **Data format.** Data is transmitted unmodified. No rounding or saturation.
- **Reset.** Reset asserted at any time, including mid-word:
  - State returns to IDLE, the FIFO is emptied, and the pointers, counters and shift register are cleared.
  - Reset values: sclk = 0, sdata = 0, sframe = 0, busy = 0, overflow = 0, fifo_level = 0.
  - The partial word is abandoned and is not resent.

## Timing
- **First-bit latency.** From a valid_in sampled at edge N with the block idle and the FIFO empty:
  - The FIFO is written at edge N.
  - The pop happens at edge N+1, and sframe, sdata (MSB) and SHIFT become visible after edge N+1.
- **Word period.** (DATA_W+1)·CLK_DIV cycles; 68 cycles with the defaults.
- **Sustained rate.** Samples arriving faster than one per word period eventually overflow. FIFO_DEPTH entries plus the word in flight absorb a burst.
- **sdata stability.** sdata is stable from the divider=0 cycle through the end of the bit, i.e. across the sclk rising edge.
- **Pulse width.** overflow is asserted for exactly the cycle following the rejected valid_in edge; it is registered.
- **fifo_level update.** fifo_level updates one cycle after the push/pop edge.

## Test plan
- **Reset.** Drive rst_n = 0 mid-word (while sframe = 1).
  - Outputs go to 0 immediately, without waiting for clk.
  - After release, fifo_level = 0, busy = 0, and no residual bits are sent.
- **Single word.** CLK_DIV = 4, one valid_in with y_in = 16'hA5C3.
  - sframe rises 1 cycle after the write edge and stays high 64 cycles.
  - Sampling sdata on the 16 sclk rising edges gives 1010_0101_1100_0011.
  - A 4-cycle gap follows, then IDLE with busy = 0.
- **Back-to-back.** Push 16'h8000, then 16'h7FFF, 2 cycles apart.
  - Two frames separated by exactly one bit-period gap.
  - Bits read back as 1000…0 and 0111…1.
- **Overflow.** Drive 6 consecutive valid_in cycles with values 1..6, starting idle.
  - Value 1 is popped at the 2nd edge; values 2–5 fill the FIFO (fifo_level = 4).
  - Value 6 is dropped, with a single 1-cycle overflow pulse.
  - Serial output is 1, 2, 3, 4, 5.
- **Push at full with simultaneous pop.** Hold the FIFO full, then assert valid_in in the GAP last cycle.
  - The sample is accepted, fifo_level stays 4, and overflow stays 0.
- **Random stream.** Random samples at random intervals averaging above the word period; a scoreboard compares serial output to accepted samples.
  - Zero mismatches.
  - Dropped count equals the number of overflow pulses.
